// File: rtl/axi_lite_reg_master.sv
// Command-driven AXI4-Lite master for single register reads/writes, with an optional
// two-beat 64-bit read (hi word at ADDR, lo word at ADDR+4) and a response-wait timeout.
module axi_lite_reg_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 12,
    parameter int C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                            clk,
    input  logic                            resetn,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic                            cmd_wide,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [31:0]                     cmd_wdata,
    input  logic [3:0]                      cmd_wstrb,

    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [63:0]                     rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic                            busy,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int CNT_W = $clog2(C_TIMEOUT_CYCLES);
    localparam int AW    = C_M_AXI_ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_AW_W,
        S_WR_B,
        S_RD_AR,
        S_RD_R,
        S_RSP
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [AW-1:0]           r_addr;
    logic                    r_wide;
    logic                    r_beat;
    logic [CNT_W-1:0]        r_cnt;

    logic                    r_awvalid;
    logic [AW-1:0]           r_awaddr;
    logic                    r_wvalid;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] r_wstrb;
    logic                    r_bready;
    logic                    r_arvalid;
    logic [AW-1:0]           r_araddr;
    logic                    r_rready;

    logic                    r_cmd_ready;
    logic                    r_busy;
    logic                    r_rsp_valid;
    logic [63:0]             r_rsp_rdata;
    logic [1:0]              r_rsp_resp;
    logic                    r_rsp_timeout;

    logic                    w_accept;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_b_hs;
    logic                    w_ar_hs;
    logic                    w_r_hs;
    logic                    w_expired;
    logic [AW-1:0]           w_cmd_addr_al;

    // Keep the first error code of a transaction; later OKAYs must not hide it.
    function automatic logic [1:0] merge_resp(input logic [1:0] cur, input logic [1:0] nxt);
        return (cur != 2'b00) ? cur : nxt;
    endfunction

    assign w_accept      = cmd_valid && r_cmd_ready;
    assign w_aw_hs       = r_awvalid && M_AXI_AWREADY;
    assign w_w_hs        = r_wvalid && M_AXI_WREADY;
    assign w_b_hs        = M_AXI_BVALID && r_bready;
    assign w_ar_hs       = r_arvalid && M_AXI_ARREADY;
    assign w_r_hs        = M_AXI_RVALID && r_rready;
    assign w_expired     = (r_cnt == CNT_W'(C_TIMEOUT_CYCLES - 1));
    assign w_cmd_addr_al = cmd_addr & ~AW'(3);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = cmd_write ? S_WR_AW_W : S_RD_AR;
                end
            end
            S_WR_AW_W: begin
                if ((!r_awvalid || M_AXI_AWREADY) && (!r_wvalid || M_AXI_WREADY)) begin
                    w_state_nxt = S_WR_B;
                end
            end
            S_WR_B: begin
                if (w_b_hs || w_expired) begin
                    w_state_nxt = S_RSP;
                end
            end
            S_RD_AR: begin
                if (w_ar_hs) begin
                    w_state_nxt = S_RD_R;
                end
            end
            S_RD_R: begin
                if (w_r_hs) begin
                    w_state_nxt = (r_wide && !r_beat) ? S_RD_AR : S_RSP;
                end else if (w_expired) begin
                    w_state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State-derived outputs are registered from the next state so every output is a flop.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_bready      <= 1'b1;
            r_rready      <= 1'b1;
            r_cmd_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_bready      <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_WR_B);
            r_rready      <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RD_R);
            r_cmd_ready   <= (w_state_nxt == S_IDLE);
            r_busy        <= (w_state_nxt != S_IDLE);
            r_rsp_valid   <= (w_state_nxt == S_RSP);
            r_cnt         <= ((r_state == S_WR_B) || (r_state == S_RD_R)) ? r_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_addr        <= '0;
            r_wide        <= 1'b0;
            r_beat        <= 1'b0;
            r_awvalid     <= 1'b0;
            r_awaddr      <= '0;
            r_wvalid      <= 1'b0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_arvalid     <= 1'b0;
            r_araddr      <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr        <= w_cmd_addr_al;
                        r_wide        <= cmd_wide && !cmd_write;
                        r_beat        <= 1'b0;
                        r_rsp_rdata   <= '0;
                        r_rsp_resp    <= 2'b00;
                        r_rsp_timeout <= 1'b0;
                        if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_awaddr  <= w_cmd_addr_al;
                            r_wvalid  <= 1'b1;
                            r_wdata   <= cmd_wdata;
                            r_wstrb   <= cmd_wstrb;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_araddr  <= w_cmd_addr_al;
                        end
                    end
                end
                S_WR_AW_W: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                    end
                end
                S_WR_B: begin
                    if (w_b_hs) begin
                        r_rsp_resp <= merge_resp(r_rsp_resp, M_AXI_BRESP);
                    end else if (w_expired) begin
                        r_rsp_resp    <= 2'b10;
                        r_rsp_timeout <= 1'b1;
                    end
                end
                S_RD_AR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                    end
                end
                S_RD_R: begin
                    if (w_r_hs) begin
                        r_rsp_resp <= merge_resp(r_rsp_resp, M_AXI_RRESP);
                        if (r_wide && !r_beat) begin
                            // High word first; the low word lives at the next (wrapping) address.
                            r_rsp_rdata[63:32] <= M_AXI_RDATA;
                            r_beat             <= 1'b1;
                            r_araddr           <= r_addr + AW'(4);
                            r_arvalid          <= 1'b1;
                        end else begin
                            r_rsp_rdata[31:0]  <= M_AXI_RDATA;
                        end
                    end else if (w_expired) begin
                        r_rsp_resp    <= 2'b10;
                        r_rsp_timeout <= 1'b1;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_timeout <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign busy          = r_busy;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_timeout   = r_rsp_timeout;

    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi_lite_reg_master.sv
// Bench for axi_lite_reg_master: a cycle-driven AXI4-Lite slave with tunable delays plus a
// memory/latency reference model computed from the command stream.
module tb_axi_lite_reg_master;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_wide;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    logic [11:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_ARREADY = 1'b0;
    logic        M_AXI_BVALID = 1'b0, M_AXI_RVALID = 1'b0;
    logic [1:0]  M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
    logic [31:0] M_AXI_RDATA = 32'h0;

    axi_lite_reg_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(12),
        .C_TIMEOUT_CYCLES  (16)
    ) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_wide(cmd_wide),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 clk = ~clk;

    // Slave knobs: READY comes dly cycles after VALID first seen; response rsp_dly cycles after handshake.
    int          aw_dly = 1, w_dly = 1, ar_dly = 1, rsp_dly = 1;
    bit          no_resp = 1'b0;
    logic [1:0]  bresp_k = 2'b00;
    logic [1:0]  rresp_k [2];

    bit          sl_b_pend = 0, sl_r_pend = 0, sl_aw_got = 0, sl_w_got = 0;
    int          sl_b_wait = 0, sl_r_wait = 0, sl_aw_age = 0, sl_w_age = 0, sl_ar_age = 0, sl_beat = 0;
    int          aw_hs = 0, w_hs = 0, b_hs = 0, r_hs = 0;
    logic [11:0] sl_aw_a, sl_r_a;
    logic [31:0] sl_w_d;
    logic [3:0]  sl_w_s;
    logic [11:0] aw_log [$];
    logic [11:0] ar_log [$];
    logic [31:0] wd_log [$];
    logic [3:0]  ws_log [$];
    logic [31:0] smem    [1024];
    logic [31:0] ref_mem [1024];

    logic        sn_awv [64], sn_wv [64], sn_arv [64], sn_rready [64];
    logic [11:0] sn_awaddr [64], sn_araddr [64];
    logic [31:0] sn_wdata [64];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task slave_step();
        M_AXI_BVALID = 1'b0;
        if (sl_b_pend && !no_resp) begin
            if (sl_b_wait <= 1) begin
                M_AXI_BVALID = 1'b1;
                M_AXI_BRESP  = bresp_k;
            end else begin
                sl_b_wait--;
            end
        end
        if (M_AXI_BVALID && M_AXI_BREADY) begin
            sl_b_pend = 0;
            b_hs++;
        end
        M_AXI_RVALID = 1'b0;
        if (sl_r_pend && !no_resp) begin
            if (sl_r_wait <= 1) begin
                M_AXI_RVALID = 1'b1;
                M_AXI_RDATA  = smem[sl_r_a[11:2]];
                M_AXI_RRESP  = rresp_k[sl_beat];
            end else begin
                sl_r_wait--;
            end
        end
        if (M_AXI_RVALID && M_AXI_RREADY) begin
            sl_r_pend = 0;
            r_hs++;
            sl_beat = (sl_beat == 0) ? 1 : 0;
        end
        if (M_AXI_AWVALID) begin sl_aw_age++; M_AXI_AWREADY = (sl_aw_age > aw_dly); end
        else begin sl_aw_age = 0; M_AXI_AWREADY = 1'b0; end
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            aw_log.push_back(M_AXI_AWADDR); sl_aw_a = M_AXI_AWADDR; sl_aw_got = 1; aw_hs++;
        end
        if (M_AXI_WVALID) begin sl_w_age++; M_AXI_WREADY = (sl_w_age > w_dly); end
        else begin sl_w_age = 0; M_AXI_WREADY = 1'b0; end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
            wd_log.push_back(M_AXI_WDATA); ws_log.push_back(M_AXI_WSTRB);
            sl_w_d = M_AXI_WDATA; sl_w_s = M_AXI_WSTRB; sl_w_got = 1; w_hs++;
        end
        if (sl_aw_got && sl_w_got) begin
            for (int i = 0; i < 4; i++)
                if (sl_w_s[i]) smem[sl_aw_a[11:2]][8*i +: 8] = sl_w_d[8*i +: 8];
            sl_aw_got = 0; sl_w_got = 0; sl_b_pend = 1; sl_b_wait = rsp_dly;
        end
        if (M_AXI_ARVALID) begin sl_ar_age++; M_AXI_ARREADY = (sl_ar_age > ar_dly); end
        else begin sl_ar_age = 0; M_AXI_ARREADY = 1'b0; end
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            ar_log.push_back(M_AXI_ARADDR); sl_r_a = M_AXI_ARADDR; sl_r_pend = 1; sl_r_wait = rsp_dly;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            slave_step();
        end
    end

    // One command end to end; expectations come from the model memory and the latency arithmetic.
    task automatic do_cmd(input bit wr, input bit wide, input logic [11:0] addr,
                          input logic [31:0] wd, input logic [3:0] ws);
        logic [11:0] a, a2;
        logic [63:0] exp_d;
        logic [1:0]  exp_r;
        int lat, cyc, beats, hold, aw0, w0, b0, r0, mx;
        a  = addr & 12'hFFC;
        a2 = a + 12'd4;
        mx = (aw_dly > w_dly) ? aw_dly : w_dly;
        beats = 0;
        if (wr) begin
            lat = 2 + mx + rsp_dly; exp_d = '0; exp_r = bresp_k;
            for (int i = 0; i < 4; i++)
                if (ws[i]) ref_mem[a[11:2]][8*i +: 8] = wd[8*i +: 8];
        end else if (wide) begin
            lat = 3 + 2*ar_dly + 2*rsp_dly; beats = 2;
            exp_d = {ref_mem[a[11:2]], ref_mem[a2[11:2]]};
            exp_r = (rresp_k[0] != 2'b00) ? rresp_k[0] : rresp_k[1];
        end else begin
            lat = 2 + ar_dly + rsp_dly; beats = 1;
            exp_d = {32'h0, ref_mem[a[11:2]]}; exp_r = rresp_k[0];
        end
        if (no_resp) begin
            lat = wr ? (18 + mx) : (18 + ar_dly); exp_d = '0; exp_r = 2'b10; beats = 0;
        end
        aw_log.delete(); ar_log.delete(); wd_log.delete(); ws_log.delete();
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; r0 = r_hs; sl_beat = 0;
        @(negedge clk);
        cmd_write = wr; cmd_wide = wide; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        cmd_valid = 1'b1;
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cyc = 0;
        do begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cyc++;
            if (cyc < 64) begin
                sn_awv[cyc] = M_AXI_AWVALID; sn_wv[cyc] = M_AXI_WVALID; sn_arv[cyc] = M_AXI_ARVALID;
                sn_rready[cyc] = M_AXI_RREADY; sn_awaddr[cyc] = M_AXI_AWADDR;
                sn_araddr[cyc] = M_AXI_ARADDR; sn_wdata[cyc] = M_AXI_WDATA;
            end
        end while (!rsp_valid && cyc < 80);
        check("latency", 64'(cyc), 64'(lat));
        check("rdata", rsp_rdata, exp_d);
        check("resp", 64'(rsp_resp), 64'(exp_r));
        check("timeout_flag", 64'(rsp_timeout), 64'(no_resp));
        hold = $urandom_range(0, 2);
        repeat (hold) @(negedge clk);
        check("rsp_hold_valid", 64'(rsp_valid), 64'd1);
        check("rsp_hold_data", rsp_rdata, exp_d);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_release", 64'({rsp_valid, rsp_timeout, cmd_ready, busy}), 64'b0010);
        if (wr) begin
            check("aw_hs_n", 64'(aw_hs - aw0), 64'd1);
            check("w_hs_n", 64'(w_hs - w0), 64'd1);
            check("b_hs_n", 64'(b_hs - b0), no_resp ? 64'd0 : 64'd1);
            if (aw_log.size() == 1 && wd_log.size() == 1) begin
                check("awaddr", 64'(aw_log[0]), 64'(a));
                check("wdata", 64'(wd_log[0]), 64'(wd));
                check("wstrb", 64'(ws_log[0]), 64'(ws));
            end else begin
                check("aw_w_log_n", 64'(aw_log.size() + wd_log.size()), 64'd2);
            end
        end else begin
            check("r_hs_n", 64'(r_hs - r0), 64'(beats));
            check("ar_n", 64'(ar_log.size()), (wide && !no_resp) ? 64'd2 : 64'd1);
            if (ar_log.size() >= 1) check("araddr0", 64'(ar_log[0]), 64'(a));
            if (wide && ar_log.size() >= 2) check("araddr1", 64'(ar_log[1]), 64'(a2));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int r0;
        rresp_k[0] = 2'b00; rresp_k[1] = 2'b00;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom; smem[i] = v; ref_mem[i] = v;
        end
        smem[0]          = 32'h1234_5678; ref_mem[0]          = 32'h1234_5678;
        smem[12'h100>>2] = 32'h0000_0001; ref_mem[12'h100>>2] = 32'h0000_0001;
        smem[12'h104>>2] = 32'h8000_0000; ref_mem[12'h104>>2] = 32'h8000_0000;

        resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_wide = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_valids", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, rsp_valid, rsp_timeout, busy}), 64'd0);
        check("rst_readys", 64'({cmd_ready, M_AXI_BREADY, M_AXI_RREADY}), 64'b111);
        check("rst_rdata", rsp_rdata, 64'd0);
        check("rst_addr_resp", 64'({M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WSTRB, rsp_resp}), 64'd0);
        check("rst_wdata", 64'(M_AXI_WDATA), 64'd0);

        do_cmd(1'b1, 1'b0, 12'h010, 32'h0000_0003, 4'hF);
        check("wr_cyc1_valids", 64'({sn_awv[1], sn_wv[1]}), 64'b11);
        check("wr_cyc1_awaddr", 64'(sn_awaddr[1]), 64'h010);
        check("wr_cyc1_wdata", 64'(sn_wdata[1]), 64'h3);

        do_cmd(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);

        do_cmd(1'b0, 1'b1, 12'h100, 32'h0, 4'h0);
        check("wide_ar2_cyc4", 64'({sn_arv[4], sn_araddr[4]}), 64'({1'b1, 12'h104}));

        aw_dly = 4;
        do_cmd(1'b1, 1'b0, 12'h020, 32'hA5A5_5A5A, 4'h5);
        check("aw_late_cyc3", 64'({sn_awv[3], sn_wv[3]}), 64'b10);
        check("aw_late_cyc5", 64'(sn_awv[5]), 64'd1);
        check("aw_late_cyc6", 64'(sn_awv[6]), 64'd0);
        aw_dly = 1;

        no_resp = 1'b1;
        do_cmd(1'b0, 1'b0, 12'h040, 32'h0, 4'h0);
        check("to_rready_in_rd_r", 64'(sn_rready[18]), 64'd1);
        check("to_rready_in_rsp", 64'(sn_rready[19]), 64'd0);
        r0 = r_hs;
        no_resp = 1'b0;
        repeat (3) @(negedge clk);
        check("stale_r_absorbed", 64'(r_hs - r0), 64'd1);
        check("stale_no_rsp", 64'({rsp_valid, busy, cmd_ready}), 64'b001);

        rresp_k[0] = 2'b10; rresp_k[1] = 2'b00;
        do_cmd(1'b0, 1'b1, 12'h200, 32'h0, 4'h0);
        rresp_k[0] = 2'b00;
        do_cmd(1'b0, 1'b1, 12'hFFE, 32'h0, 4'h0);

        no_resp = 1'b1;
        @(negedge clk);
        cmd_write = 1'b0; cmd_wide = 1'b0; cmd_addr = 12'h080; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_busy", 64'({busy, M_AXI_RREADY}), 64'b11);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        sl_r_pend = 0;
        no_resp = 1'b0;
        check("midrst_idle", 64'({M_AXI_ARVALID, rsp_valid, cmd_ready, busy, M_AXI_RREADY}), 64'b00101);
        @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            aw_dly  = $urandom_range(0, 3);
            w_dly   = $urandom_range(0, 3);
            ar_dly  = $urandom_range(0, 3);
            rsp_dly = $urandom_range(1, 4);
            bresp_k    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            rresp_k[0] = ($urandom_range(0, 2) != 0) ? 2'b00 : 2'($urandom_range(1, 3));
            rresp_k[1] = ($urandom_range(0, 2) != 0) ? 2'b00 : 2'($urandom_range(1, 3));
            do_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom),
                   $urandom, 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_lite_reg_master.md
Name: axi_lite_reg_master

Overview:
Command-driven AXI4-Lite master that issues single register reads and writes to the analyzer's CPU register slaves. It is used by the on-chip test sequencer and by the verification harness. It is the initiator counterpart of the register slave. A wide-read mode fetches a 64-bit counter as two sequential 32-bit reads: high word at ADDR, low word at ADDR+4. Response waits are guarded by a timeout so a dead slave cannot hang the sequencer.

Parameters:
C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_M_AXI_ADDR_WIDTH, 12, AXI address width.
C_TIMEOUT_CYCLES, 1024, maximum cycles to wait for BVALID/RVALID; must be >= 2.

Ports:
clk  in  1  clock; the AXI interface is also on clk.
resetn  in  1  synchronous, active-low reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  high only in IDLE.
cmd_write  in  1  1 = write, 0 = read.
cmd_wide  in  1  read only: 64-bit two-beat read; ignored on writes.
cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address; bits [1:0] forced to 0 on the bus.
cmd_wdata  in  32  write data.
cmd_wstrb  in  4  write strobes.
rsp_valid  out  1  response available.
rsp_ready  in  1  response accepted.
rsp_rdata  out  64  read data: {hi,lo} for wide, {32'h0,word} for narrow, 0 for writes.
rsp_resp  out  2  first non-OKAY BRESP/RRESP seen, else 2'b00; 2'b10 on timeout.
rsp_timeout  out  1  response wait timed out.
busy  out  1  high whenever state != IDLE.
M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY  standard AXI4-Lite master ports.

Behaviour:
- Reset: state=IDLE.
  - Low after reset: all VALIDs, rsp_valid, rsp_timeout, busy.
  - Zero after reset: rsp_rdata, rsp_resp, AWADDR, ARADDR, WDATA, WSTRB.
  - BREADY=RREADY=1; IDLE absorbs stray responses.
- All AXI outputs are registered; no combinational path from any input to any output.
- Command accept: a command is taken on cmd_valid&&cmd_ready. The address, data, strobes and wide flag are latched. The beat index and timeout counter are cleared.
- IDLE -> WR_AW_W (write) or RD_AR (read):
  - The matching VALIDs rise on the cycle after accept.
  - In both states BREADY and RREADY are 0.
- WR_AW_W:
  - AWVALID and WVALID are each held until their own handshake, then dropped independently.
  - Either order is accepted, including both in the same cycle.
  - When both channels are done -> WR_B.
  - There is no timeout in this state; VALIDs are never withdrawn.
- WR_B: BREADY=1. On BVALID, capture BRESP -> RSP.
- RD_AR: ARVALID is held until ARREADY, then -> RD_R.
- RD_R: RREADY=1. On RVALID, store RDATA into hi (beat 0 of wide) or lo, and merge RRESP.
  - Wide read, beat 0: -> RD_AR with ARADDR = latched addr + 4, where the +4 wraps modulo 2^C_M_AXI_ADDR_WIDTH.
  - Otherwise: -> RSP.
- Timeout:
  - The counter increments every cycle in WR_B and RD_R and resets on entry to each of those states.
  - When it reaches C_TIMEOUT_CYCLES-1 with no handshake: drop BREADY/RREADY, set rsp_timeout=1 and rsp_resp=2'b10, -> RSP.
  - A handshake in that same cycle wins over the timeout.
  - After a timeout the bench must reset the slave. Stale responses are only absorbed while in IDLE.
- RSP: rsp_valid=1, and the response fields are stable until rsp_ready.
  - On rsp_valid&&rsp_ready -> IDLE, clearing rsp_valid and rsp_timeout.
  - cmd_ready rises the cycle after the response is accepted.
- Response merge: rsp_resp keeps the first non-OKAY code. A later OKAY never overwrites it.
- Latency against a slave that asserts READY one cycle after VALID and responds one cycle after the address handshake (accept = cycle 0):
  - Write: AWVALID/WVALID at cycle 1, rsp_valid at cycle 4.
  - Narrow read: rsp_valid at cycle 4.
  - Wide read: second ARVALID at cycle 4, rsp_valid at cycle 7.
- Reset mid-transaction: return to IDLE next cycle; all VALIDs and rsp_valid are low on the following cycle.

Test Plan:
- Write 0x0000_0003 to 0x010, wstrb=4'hF, responsive slave -> AWADDR=0x010 and WDATA=0x3 on cycle 1; rsp_valid at cycle 4; rsp_resp=00; rsp_rdata=0.
- Narrow read 0x000 with slave returning 0x1234_5678 -> rsp_rdata=0x0000_0000_1234_5678 at cycle 4.
- Wide read 0x100 with slave returning 0x0000_0001 @0x100 and 0x8000_0000 @0x104 -> two AR beats at 0x100 then 0x104; rsp_rdata=0x0000_0001_8000_0000 at cycle 7.
- Slave delays AWREADY 3 cycles after WREADY -> WVALID drops after its handshake, AWVALID stays high until AWREADY; exactly one B handshake; a single response.
- C_TIMEOUT_CYCLES=16, slave never asserts RVALID -> rsp_timeout=1 and rsp_resp=10 exactly 16 cycles after entering RD_R; RREADY low in RSP.
- Wide read with RRESP=10 on beat 0 and 00 on beat 1 -> rsp_resp=10; resetn pulsed during RD_R -> IDLE, ARVALID=0, rsp_valid=0, cmd_ready=1.
